// File: rtl/lm32_logic_op_recover.sv
// lm32_logic_op_recover
//   Rebuilds the 4-bit LM32 logic_op truth table from observed
//   (operand_0, operand_1, result) word triples. The minterm index of bit i is
//   {operand_1[i], operand_0[i]}. A result that no single logic op can explain
//   is flagged as a conflict. A run that reaches MAX_SAMPLES samples with
//   minterms still unknown is flagged as a timeout.
//   Optional feature macro: LM32_LOGIC_RECOVER_DIAG_EN adds conflict_bit_x and
//   conflict_minterm_x, which give the position and minterm of the first
//   conflicting bit.
module lm32_logic_op_recover #(
  parameter int WORD_WIDTH  = 32,
  parameter int MAX_SAMPLES = 16,
  parameter int CNT_WIDTH   = 5
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_x,
  input  logic                  sample_valid_x,
  output logic                  sample_ready_x,
  input  logic [WORD_WIDTH-1:0] operand_0_x,
  input  logic [WORD_WIDTH-1:0] operand_1_x,
  input  logic [WORD_WIDTH-1:0] logic_result_x,
  output logic [3:0]            recovered_op_x,
  output logic [3:0]            op_known_x,
  output logic                  done_x,
  output logic                  conflict_x,
  output logic                  timeout_x,
`ifdef LM32_LOGIC_RECOVER_DIAG_EN
  output logic [$clog2(WORD_WIDTH)-1:0] conflict_bit_x,
  output logic [1:0]                    conflict_minterm_x,
`endif
  output logic [CNT_WIDTH-1:0]  sample_count_x
);

  typedef enum logic [1:0] {IDLE, COLLECT, DONE, ERROR} state_t;

  state_t               state_q, state_d;
  logic [3:0]           op_q, op_d;
  logic [3:0]           known_q, known_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 done_q, done_d;
  logic                 conf_q, conf_d;
  logic                 tmo_q, tmo_d;

  logic                  accept;
  logic [WORD_WIDTH-1:0] match [4];
  logic [3:0]            hit, v1, v0;
  logic [3:0]            new_mask;
  logic [3:0]            known_upd;
  logic [3:0]            op_upd;
  logic                  conflict;
  logic [CNT_WIDTH:0]    cnt_inc;
  logic                  timeout_hit;

  assign sample_ready_x = (state_q == COLLECT) & ~start_x;
  assign accept         = sample_valid_x & sample_ready_x;

  // Per-minterm bit masks and the hit / result-one / result-zero summaries.
  for (genvar gi = 0; gi < 4; gi++) begin : g_minterm
    localparam logic [1:0] M = 2'(gi);
    assign match[gi] = ~({WORD_WIDTH{M[1]}} ^ operand_1_x) &
                       ~({WORD_WIDTH{M[0]}} ^ operand_0_x);
    assign hit[gi] = |match[gi];
    assign v1[gi]  = |(match[gi] & logic_result_x);
    assign v0[gi]  = |(match[gi] & ~logic_result_x);
  end

  // A minterm contradicts itself within the sample, or disagrees with what an earlier sample established.
  assign conflict  = (|(v1 & v0)) | (|(known_q & hit & (v1 ^ op_q)));
  assign new_mask  = hit & ~known_q;
  assign known_upd = known_q | hit;
  assign op_upd    = (op_q & ~new_mask) | (v1 & new_mask);

  assign cnt_inc     = {1'b0, cnt_q} + (CNT_WIDTH+1)'(1);
  assign timeout_hit = (MAX_SAMPLES != 0) && (cnt_inc == (CNT_WIDTH+1)'(MAX_SAMPLES));

`ifdef LM32_LOGIC_RECOVER_DIAG_EN
  localparam int BIT_W = $clog2(WORD_WIDTH);

  logic [BIT_W-1:0]      cbit_q, cbit_d;
  logic [1:0]            cmin_q, cmin_d;
  logic [WORD_WIDTH-1:0] bad_bits [4];
  logic [WORD_WIDTH-1:0] bit_conf;
  logic [BIT_W-1:0]      cbit_pos;

  // A bit is bad if it differs from the lowest bit of its own minterm or from the already-known value of that minterm.
  for (genvar gi = 0; gi < 4; gi++) begin : g_diag
    logic [WORD_WIDTH-1:0] first_sel;
    logic                  first_res;
    assign first_sel    = match[gi] & (~match[gi] + WORD_WIDTH'(1));
    assign first_res    = |(first_sel & logic_result_x);
    assign bad_bits[gi] = match[gi] &
                          ((logic_result_x ^ {WORD_WIDTH{first_res}}) |
                           ({WORD_WIDTH{known_q[gi]}} & (logic_result_x ^ {WORD_WIDTH{op_q[gi]}})));
  end

  assign bit_conf = bad_bits[0] | bad_bits[1] | bad_bits[2] | bad_bits[3];

  // Lowest-index bad bit; scanning downward lets the lowest index win.
  always_comb begin
    cbit_pos = '0;
    for (int i = WORD_WIDTH - 1; i >= 0; i--) begin
      if (bit_conf[i]) cbit_pos = BIT_W'(i);
    end
  end

  assign conflict_bit_x     = cbit_q;
  assign conflict_minterm_x = cmin_q;
`endif

  // Next-state and next-register values for the run controller.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    known_d = known_q;
    cnt_d   = cnt_q;
    done_d  = done_q;
    conf_d  = conf_q;
    tmo_d   = tmo_q;
`ifdef LM32_LOGIC_RECOVER_DIAG_EN
    cbit_d  = cbit_q;
    cmin_d  = cmin_q;
`endif
    if (start_x) begin
      state_d = COLLECT;
      op_d    = '0;
      known_d = '0;
      cnt_d   = '0;
      done_d  = 1'b0;
      conf_d  = 1'b0;
      tmo_d   = 1'b0;
`ifdef LM32_LOGIC_RECOVER_DIAG_EN
      cbit_d  = '0;
      cmin_d  = '0;
`endif
    end else if (accept) begin
      cnt_d = cnt_inc[CNT_WIDTH] ? cnt_q : cnt_inc[CNT_WIDTH-1:0];
      if (conflict) begin
        // A conflicting sample leaves the table as it was.
        state_d = ERROR;
        conf_d  = 1'b1;
`ifdef LM32_LOGIC_RECOVER_DIAG_EN
        cbit_d  = cbit_pos;
        cmin_d  = {operand_1_x[cbit_pos], operand_0_x[cbit_pos]};
`endif
      end else begin
        op_d    = op_upd;
        known_d = known_upd;
        if (known_upd == 4'hF) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else if (timeout_hit) begin
          state_d = ERROR;
          tmo_d   = 1'b1;
        end
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      op_q    <= '0;
      known_q <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      conf_q  <= 1'b0;
      tmo_q   <= 1'b0;
`ifdef LM32_LOGIC_RECOVER_DIAG_EN
      cbit_q  <= '0;
      cmin_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      known_q <= known_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      conf_q  <= conf_d;
      tmo_q   <= tmo_d;
`ifdef LM32_LOGIC_RECOVER_DIAG_EN
      cbit_q  <= cbit_d;
      cmin_q  <= cmin_d;
`endif
    end
  end

  assign recovered_op_x = op_q;
  assign op_known_x     = known_q;
  assign done_x         = done_q;
  assign conflict_x     = conf_q;
  assign timeout_x      = tmo_q;
  assign sample_count_x = cnt_q;

endmodule
